// File: rtl/pixel_lookup_if.sv
// pixel_lookup_if: bundles the pixel-stage bus of pixel_lookup.
//   - motion-object hit info and playfield tile coordinates (upstream -> stage)
//   - dual-port picture ROM address/data (stage <-> ROM)
//   - resolved colour index, source flag, valid and collision status (stage -> palette)
// master: the environment side (upstream stages, ROM, palette/CPU).
// slave:  the pixel_lookup stage itself.
interface pixel_lookup_if;
  logic        pix_valid_in;
  logic        motionSel;
  logic        motionWide;
  logic [7:0]  spriteID;
  logic [2:0]  mob_row;
  logic [2:0]  mob_col;
  logic [7:0]  pf_tile;
  logic [2:0]  pf_row;
  logic [2:0]  pf_col;
  logic [11:0] rom_addr_a;
  logic [11:0] rom_addr_b;
  logic [15:0] rom_data_a;
  logic [15:0] rom_data_b;
  logic [1:0]  color_idx;
  logic        color_src;
  logic        pix_valid_out;
  logic        coll_flag;
  logic        coll_clr;

  modport master (
    output pix_valid_in, motionSel, motionWide, spriteID, mob_row, mob_col,
    output pf_tile, pf_row, pf_col, rom_data_a, rom_data_b, coll_clr,
    input  rom_addr_a, rom_addr_b, color_idx, color_src, pix_valid_out, coll_flag
  );

  modport slave (
    input  pix_valid_in, motionSel, motionWide, spriteID, mob_row, mob_col,
    input  pf_tile, pf_row, pf_col, rom_data_a, rom_data_b, coll_clr,
    output rom_addr_a, rom_addr_b, color_idx, color_src, pix_valid_out, coll_flag
  );
endinterface

// File: rtl/pixel_lookup.sv
// pixel_lookup: pixel-pipeline stage after motionObjects.
// Generates playfield (port A) and motion-object (port B) picture ROM addresses, selects the
// addressed pixel out of both returned bitplane pairs, resolves mob-over-playfield priority
// with transparency and keeps a sticky mob/playfield collision flag.
// Ports:
//   clk   - system clock
//   rst_l - asynchronous active-low reset
//   bus   - pixel_lookup_if.slave: pixel inputs, ROM address/data, colour outputs, collision
// Latency is two clocks from pix_valid_in to pix_valid_out, one pixel per clock, no stalls.
module pixel_lookup #(
  parameter int unsigned LATENCY = 2,
  parameter logic [1:0]  XPARENT = 2'b00
) (
  input  logic           clk,
  input  logic           rst_l,
  pixel_lookup_if.slave  bus
);

  // The pipeline depth is fixed by construction; other values cannot be honoured.
  if (LATENCY != 2) begin : g_bad_latency
    $error("pixel_lookup: LATENCY must be 2");
  end

  // Stage 0: address generation
  logic [2:0] mob_row_eff;
  logic [2:0] mob_col_eff;

  always_comb begin
    mob_row_eff    = bus.spriteID[7] ? ~bus.mob_row : bus.mob_row;
    mob_col_eff    = bus.spriteID[6] ? ~bus.mob_col : bus.mob_col;
    bus.rom_addr_a = {1'b0, bus.pf_tile, bus.pf_row};
    bus.rom_addr_b = {1'b1, 1'b0, bus.spriteID[5:0], bus.motionWide, mob_row_eff};
  end

  // Stage 1: per-pixel state kept alongside the ROM access
  logic       s1_valid_q;
  logic       s1_sel_q;
  logic [2:0] s1_pf_col_q;
  logic [2:0] s1_mob_col_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid_q   <= 1'b0;
      s1_sel_q     <= 1'b0;
      s1_pf_col_q  <= 3'd0;
      s1_mob_col_q <= 3'd0;
    end else begin
      s1_valid_q   <= bus.pix_valid_in;
      s1_sel_q     <= bus.motionSel;
      s1_pf_col_q  <= bus.pf_col;
      s1_mob_col_q <= mob_col_eff;
    end
  end

  // Bit 7 of each plane is the leftmost pixel, so column c sits at bit 7-c == ~c.
  logic [1:0] pf_pix;
  logic [1:0] mob_pix;
  logic       use_mob;
  logic       coll_set;

  always_comb begin
    pf_pix   = {bus.rom_data_a[{1'b1, ~s1_pf_col_q}], bus.rom_data_a[{1'b0, ~s1_pf_col_q}]};
    mob_pix  = {bus.rom_data_b[{1'b1, ~s1_mob_col_q}], bus.rom_data_b[{1'b0, ~s1_mob_col_q}]};
    use_mob  = s1_valid_q && s1_sel_q && (mob_pix != XPARENT);
    coll_set = use_mob && (pf_pix != 2'b00);
  end

  // Output register and collision flag
  logic [1:0] color_idx_q, color_idx_d;
  logic       color_src_q, color_src_d;
  logic       valid_out_q;
  logic       coll_q, coll_d;

  always_comb begin
    color_idx_d = 2'b00;
    color_src_d = 1'b0;
    if (s1_valid_q) begin
      if (use_mob) begin
        color_idx_d = mob_pix;
        color_src_d = 1'b1;
      end else begin
        color_idx_d = pf_pix;
      end
    end
    // A collision in the same cycle as a clear keeps the flag set.
    if (coll_set) begin
      coll_d = 1'b1;
    end else if (bus.coll_clr) begin
      coll_d = 1'b0;
    end else begin
      coll_d = coll_q;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      color_idx_q <= 2'b00;
      color_src_q <= 1'b0;
      valid_out_q <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      color_idx_q <= color_idx_d;
      color_src_q <= color_src_d;
      valid_out_q <= s1_valid_q;
      coll_q      <= coll_d;
    end
  end

  assign bus.color_idx     = color_idx_q;
  assign bus.color_src     = color_src_q;
  assign bus.pix_valid_out = valid_out_q;
  assign bus.coll_flag     = coll_q;

endmodule
